time_overlay: RTL and testbench

TIME_OVERLAY -- requirements
Module: time_overlay

---
 rtl/time_overlay.sv | 187 ++++++++++++++++++
 tb/tb_time_overlay.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/time_overlay.sv
// time_overlay: renders an hh:mm:ss overlay into an image memory.
// Glyph rows are fetched from a character ROM and written pixel by pixel.
module time_overlay #(
    parameter int unsigned ORG_X    = 76,
    parameter int unsigned ORG_Y    = 116,
    parameter logic [23:0] FG_COLOR = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  hour_bcd,
    input  logic [7:0]  min_bcd,
    input  logic [7:0]  sec_bcd,
    input  logic [19:0] fb_base,
    output logic        busy,
    output logic        done,
    output logic [19:0] IM_A,
    output logic [23:0] IM_D,
    output logic        IM_WEN,
    output logic [8:0]  CR_A,
    input  logic [12:0] CR_Q
);

    localparam int unsigned GLYPH_W    = 13;
    localparam int unsigned GLYPH_H    = 24;
    localparam int unsigned NUM_CHARS  = 8;
    localparam int unsigned FB_STRIDE  = 256;
    localparam int unsigned COLON_CODE = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PIX,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic [19:0] base_q, base_d;
    logic [2:0]  k_q, k_d;
    logic [4:0]  r_q, r_d;
    logic [3:0]  c_q, c_d;
    logic [12:0] row_q, row_d;
    logic        busy_q, busy_d, done_q, done_d, im_wen_q, im_wen_d;
    logic [19:0] im_a_q, im_a_d;
    logic [23:0] im_d_q, im_d_d;
    logic [8:0]  cr_a_q, cr_a_d;

    logic [4:0]  sel_next, sel_cur;
    logic [3:0]  code_next;
    logic        blank_cur;
    logic [3:0]  bit_idx;
    logic        pix_bit;

    // Character k as {is_colon, bcd nibble} in h1 h0 : m1 m0 : s1 s0 order
    function automatic logic [4:0] char_sel(input logic [2:0] k, input logic [7:0] h,
                                            input logic [7:0] m, input logic [7:0] s);
        logic [4:0] res;
        case (k)
            3'd0:    res = {1'b0, h[7:4]};
            3'd1:    res = {1'b0, h[3:0]};
            3'd3:    res = {1'b0, m[7:4]};
            3'd4:    res = {1'b0, m[3:0]};
            3'd6:    res = {1'b0, s[7:4]};
            3'd7:    res = {1'b0, s[3:0]};
            default: res = {1'b1, 4'd0};
        endcase
        return res;
    endfunction

    // State register and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            hour_q   <= '0;
            min_q    <= '0;
            sec_q    <= '0;
            base_q   <= '0;
            k_q      <= '0;
            r_q      <= '0;
            c_q      <= '0;
            row_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            im_wen_q <= 1'b1;
            im_a_q   <= '0;
            im_d_q   <= '0;
            cr_a_q   <= '0;
        end else begin
            state_q  <= state_d;
            hour_q   <= hour_d;
            min_q    <= min_d;
            sec_q    <= sec_d;
            base_q   <= base_d;
            k_q      <= k_d;
            r_q      <= r_d;
            c_q      <= c_d;
            row_q    <= row_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            im_wen_q <= im_wen_d;
            im_a_q   <= im_a_d;
            im_d_q   <= im_d_d;
            cr_a_q   <= cr_a_d;
        end
    end

    // Next-state sequencing; outputs are derived from the next state so they align with it
    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        base_d  = base_q;
        k_d     = k_q;
        r_d     = r_q;
        c_d     = c_q;
        row_d   = row_q;

        sel_cur   = char_sel(k_q, hour_q, min_q, sec_q);
        blank_cur = !sel_cur[4] && (sel_cur[3:0] > 4'd9);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    hour_d  = hour_bcd;
                    min_d   = min_bcd;
                    sec_d   = sec_bcd;
                    base_d  = fb_base;
                    k_d     = '0;
                    r_d     = '0;
                    c_d     = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                row_d   = blank_cur ? 13'd0 : CR_Q;
                c_d     = '0;
                state_d = S_PIX;
            end
            S_PIX: begin
                if (c_q == 4'(GLYPH_W - 1)) begin
                    c_d = '0;
                    if (r_q == 5'(GLYPH_H - 1)) begin
                        r_d = '0;
                        if (k_q == 3'(NUM_CHARS - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            k_d     = 3'(k_q + 3'd1);
                            state_d = S_FETCH;
                        end
                    end else begin
                        r_d     = 5'(r_q + 5'd1);
                        state_d = S_FETCH;
                    end
                end else begin
                    c_d = 4'(c_q + 4'd1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        sel_next  = char_sel(k_d, hour_d, min_d, sec_d);
        code_next = sel_next[4] ? 4'(COLON_CODE) : sel_next[3:0];
        cr_a_d    = 9'(9'(code_next) * 9'(GLYPH_H) + 9'(r_d));

        bit_idx  = 4'(4'(GLYPH_W - 1) - c_d);
        pix_bit  = row_d[bit_idx];
        im_wen_d = !((state_d == S_PIX) && pix_bit);
        im_a_d   = 20'(32'(base_d) + (ORG_Y + 32'(r_d)) * FB_STRIDE + ORG_X
                       + GLYPH_W * 32'(k_d) + 32'(c_d));
        im_d_d   = im_wen_d ? 24'd0 : FG_COLOR;
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign IM_WEN = im_wen_q;
    assign IM_A   = im_a_q;
    assign IM_D   = im_d_q;
    assign CR_A   = cr_a_q;

endmodule

// File: tb/tb_time_overlay.sv
// tb_time_overlay: directed renders checked against a bench-side golden model.
module tb_time_overlay;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  hour_bcd, min_bcd, sec_bcd;
    logic [19:0] fb_base;
    logic        busy, done, IM_WEN;
    logic [19:0] IM_A;
    logic [23:0] IM_D;
    logic [8:0]  CR_A;
    logic [12:0] CR_Q;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [19:0] a;
        logic [23:0] d;
        int          cyc;
    } wr_t;

    wr_t exp_q[$];
    wr_t got_q[$];

    time_overlay dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .hour_bcd(hour_bcd),
        .min_bcd (min_bcd),
        .sec_bcd (sec_bcd),
        .fb_base (fb_base),
        .busy    (busy),
        .done    (done),
        .IM_A    (IM_A),
        .IM_D    (IM_D),
        .IM_WEN  (IM_WEN),
        .CR_A    (CR_A),
        .CR_Q    (CR_Q)
    );

    always #5 clk = ~clk;

    // Character ROM: digit 1 row 0 is a single leftmost pixel, everything else hashed
    function automatic logic [12:0] rom(input logic [8:0] a);
        logic [31:0] t;
        if (a == 9'd24) return 13'h1000;
        t = (32'(a) + 32'd1) * 32'd2654435761;
        return t[27:15];
    endfunction

    always @(posedge clk) CR_Q <= rom(CR_A);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int code_of(input int k, input logic [7:0] h, input logic [7:0] m,
                                   input logic [7:0] s);
        logic [3:0] n;
        case (k)
            0: n = h[7:4];
            1: n = h[3:0];
            3: n = m[7:4];
            4: n = m[3:0];
            6: n = s[7:4];
            7: n = s[3:0];
            default: return 10;
        endcase
        return (n > 4'd9) ? -1 : int'(n);
    endfunction

    task automatic build_exp(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                             input logic [19:0] base);
        logic [12:0] row;
        int code;
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            code = code_of(k, h, m, s);
            for (int r = 0; r < 24; r++) begin
                row = (code < 0) ? 13'd0 : rom(9'(code * 24 + r));
                for (int c = 0; c < 13; c++) begin
                    if (row[12-c])
                        exp_q.push_back('{20'(32'(base) + (116 + r) * 256 + 76 + 13 * k + c),
                                          24'hFFFFFF, (k * 24 + r) * 15 + 3 + c});
                end
            end
        end
    endtask

    // One render: start, optional extra starts, optional reset; records writes per cycle
    task automatic run(input string name, input logic [7:0] h, input logic [7:0] m,
                       input logic [7:0] s, input logic [19:0] base, input int rs1,
                       input int rs2, input int rst_at);
        int done_cyc = -1;
        int ndone    = 0;
        int n_cmp;
        int n_exp;
        build_exp(h, m, s, base);
        got_q.delete();
        @(negedge clk);
        hour_bcd = h; min_bcd = m; sec_bcd = s; fb_base = base; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 2890; cyc++) begin
            if (!IM_WEN) got_q.push_back('{IM_A, IM_D, cyc});
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc == rst_at) begin
                reset = 1'b0;
                #1;
                chk({name, " rst_wen"}, 32'(IM_WEN), 32'd1);
                chk({name, " rst_busy"}, 32'(busy), 32'd0);
                chk({name, " rst_ima"}, 32'(IM_A), 32'd0);
                repeat (2) @(negedge clk);
                reset = 1'b1;
                n_exp = 0;
                foreach (exp_q[i]) if (exp_q[i].cyc <= rst_at) n_exp++;
                chk({name, " pre_rst_writes"}, 32'(got_q.size()), 32'(n_exp));
                got_q.delete();
                for (int j = 0; j < 20; j++) begin
                    @(negedge clk);
                    if (!IM_WEN || busy || done) got_q.push_back('{IM_A, IM_D, j});
                end
                chk({name, " post_rst_quiet"}, 32'(got_q.size()), 32'd0);
                return;
            end
            if (cyc == 1)    chk({name, " busy_c1"}, 32'(busy), 32'd1);
            if (cyc == 2881) chk({name, " busy_done"}, 32'(busy), 32'd1);
            if (cyc == 2882) chk({name, " busy_after"}, 32'(busy), 32'd0);
            if (cyc == 10) begin
                hour_bcd = 8'h77; min_bcd = 8'h88; sec_bcd = 8'h11; fb_base = 20'h12345;
            end
            start = (cyc == rs1 || cyc == rs2);
            @(negedge clk);
        end
        start = 1'b0;
        chk({name, " done_cyc"}, 32'(done_cyc), 32'd2881);
        chk({name, " done_cnt"}, 32'(ndone), 32'd1);
        chk({name, " n_writes"}, 32'(got_q.size()), 32'(exp_q.size()));
        n_cmp = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n_cmp; i++) begin
            if (got_q[i].a !== exp_q[i].a || got_q[i].d !== exp_q[i].d ||
                got_q[i].cyc != exp_q[i].cyc) begin
                chk({name, " wr_addr"}, 32'(got_q[i].a), 32'(exp_q[i].a));
                chk({name, " wr_data"}, 32'(got_q[i].d), 32'(exp_q[i].d));
                chk({name, " wr_cyc"}, 32'(got_q[i].cyc), 32'(exp_q[i].cyc));
                break;
            end
        end
        if (n_cmp > 0) chk({name, " last_wr_addr"}, 32'(got_q[n_cmp-1].a),
                           32'(exp_q[n_cmp-1].a));
    endtask

    initial begin
        int n;
        reset = 1'b0; start = 1'b0;
        hour_bcd = '0; min_bcd = '0; sec_bcd = '0; fb_base = '0;
        repeat (3) @(negedge clk);
        chk("reset_wen", 32'(IM_WEN), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_ima", 32'(IM_A), 32'd0);
        chk("reset_imd", 32'(IM_D), 32'd0);
        chk("reset_cra", 32'(CR_A), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 12:34:56 with ignored restarts at cycles 5 and 2000
        run("t123456", 8'h12, 8'h34, 8'h56, 20'h0, 5, 2000, -1);

        // 10:00:00: single leftmost pixel in the first row of digit 1
        run("t100000", 8'h10, 8'h00, 8'h00, 20'h0, -1, -1, -1);
        chk("t100000 first_addr", (got_q.size() > 0) ? 32'(got_q[0].a) : 32'hFFFFFFFF, 32'd29772);
        n = 0;
        foreach (got_q[i]) if (got_q[i].cyc >= 3 && got_q[i].cyc <= 15) n++;
        chk("t100000 row0_writes", 32'(n), 32'd1);

        // Address wrap past 2^20
        run("twrap", 8'h12, 8'h34, 8'h56, 20'hFFFF0, -1, -1, -1);

        // Invalid hour tens digit renders blank
        run("tblank", 8'hA5, 8'h59, 8'h07, 20'h00400, -1, -1, -1);
        n = 0;
        foreach (got_q[i]) if (got_q[i].cyc <= 360) n++;
        chk("tblank k0_writes", 32'(n), 32'd0);

        // Reset mid-render, then a full render recovers
        run("treset", 8'h12, 8'h34, 8'h56, 20'h0, -1, -1, 900);
        run("t235959", 8'h23, 8'h59, 8'h59, 20'h01000, -1, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
